// File: rtl/fsm_ones_detector_param.sv
// Moore detector that raises Dout once COUNT sampled ones have been seen.
// Supports cumulative/consecutive counting, sticky/pulse Done, and clear/enable.
module fsm_ones_detector_param #(
  parameter int COUNT  = 2,
  parameter int CNT_W  = 4,
  parameter int MODE   = 0,
  parameter int CONSEC = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Clear,
  input  logic             Din,
  output logic             Dout,
  output logic [CNT_W-1:0] Count,
  output logic [2:0]       State
);

  if ((COUNT < 1) || (COUNT > (2 ** CNT_W) - 1)) begin : g_bad_count
    $fatal(1, "fsm_ones_detector_param: COUNT=%0d outside 1..2^CNT_W-1", COUNT);
  end

  typedef enum logic [2:0] {
    S_START  = 3'b001,
    S_MIDWAY = 3'b010,
    S_DONE   = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] COUNT_V = CNT_W'(COUNT);
  localparam logic [CNT_W-1:0] ONE_V   = CNT_W'(1);
  localparam logic [2:0] FIRST_HIT_STATE = (COUNT == 1) ? S_DONE : S_MIDWAY;

  // Held as a plain vector so a corrupted (non-one-hot) value is representable.
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             hit;

  assign hit = Enable & Din;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_START;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (Clear) begin
      state_d = S_START;
      count_d = '0;
    end else begin
      case (state_q)
        S_START: begin
          if (hit) begin
            state_d = FIRST_HIT_STATE;
            count_d = ONE_V;
          end
        end
        S_MIDWAY: begin
          // count_q < COUNT here, so the increment cannot wrap.
          if (hit) begin
            count_d = count_q + ONE_V;
            state_d = ((count_q + ONE_V) == COUNT_V) ? S_DONE : S_MIDWAY;
          end else if (Enable && (CONSEC != 0)) begin
            state_d = S_START;
            count_d = '0;
          end
        end
        S_DONE: begin
          if (MODE != 0) begin
            // Pulse mode leaves Done unconditionally; a hit here opens the next run.
            if (hit) begin
              state_d = FIRST_HIT_STATE;
              count_d = ONE_V;
            end else begin
              state_d = S_START;
              count_d = '0;
            end
          end else begin
            count_d = COUNT_V;
          end
        end
        default: begin
          state_d = S_START;
          count_d = '0;
        end
      endcase
    end
  end

  assign Dout  = (state_q == S_DONE);
  assign Count = count_q;
  assign State = state_q;

endmodule

// File: tb/tb_fsm_ones_detector_param.sv
// Bench for fsm_ones_detector_param: five parameter sets driven in parallel,
// directed scenarios plus random stimulus against a run-length reference model.
module tb_fsm_ones_detector_param;

  localparam int NI = 5;
  // Instances: 0 default, 1 consec COUNT=3, 2 pulse COUNT=2, 3 sticky COUNT=1, 4 pulse+consec COUNT=3
  localparam int P_COUNT  [NI] = '{2, 3, 2, 1, 3};
  localparam int P_MODE   [NI] = '{0, 0, 1, 0, 1};
  localparam int P_CONSEC [NI] = '{0, 1, 0, 0, 1};

  logic       Clock;
  logic       Reset;
  logic       Enable;
  logic       Clear;
  logic       Din;
  logic       dout_a [NI];
  logic [3:0] cnt_a  [NI];
  logic [2:0] st_a   [NI];

  int n_checks;
  int n_fail;
  int m_cnt [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fsm_ones_detector_param #(
      .COUNT (P_COUNT[g]),
      .CNT_W (4),
      .MODE  (P_MODE[g]),
      .CONSEC(P_CONSEC[g])
    ) u_dut (
      .Clock (Clock),
      .Reset (Reset),
      .Enable(Enable),
      .Clear (Clear),
      .Din   (Din),
      .Dout  (dout_a[g]),
      .Count (cnt_a[g]),
      .State (st_a[g])
    );
  end

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: a run is just an integer number of ones seen so far.
  function automatic int model_next(int cnt, int idx, logic en, logic din, logic clr);
    logic h;
    h = en & din;
    if (clr) return 0;
    if (cnt == P_COUNT[idx]) begin
      if (P_MODE[idx] == 0) return cnt;
      return h ? 1 : 0;
    end
    if (h) return cnt + 1;
    if (en && !din && P_CONSEC[idx] != 0) return 0;
    return cnt;
  endfunction

  function automatic logic [2:0] model_state(int cnt, int idx);
    if (cnt == 0) return 3'b001;
    if (cnt == P_COUNT[idx]) return 3'b100;
    return 3'b010;
  endfunction

  // Driver tasks
  task automatic do_reset();
    @(negedge Clock);
    Enable = 1'b0; Din = 1'b0; Clear = 1'b0;
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    for (int i = 0; i < NI; i++) m_cnt[i] = 0;
  endtask

  task automatic step(input logic en, input logic din, input logic clr);
    @(negedge Clock);
    Enable = en; Din = din; Clear = clr;
    @(posedge Clock);
    for (int i = 0; i < NI; i++) m_cnt[i] = model_next(m_cnt[i], i, en, din, clr);
    #1;
  endtask

  // Scenarios
  task automatic test_reset();
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (st_a[i] !== 3'b001 || cnt_a[i] !== 4'd0 || dout_a[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: state=%b count=%0d dout=%b, want state=001 count=0 dout=0",
                 i, st_a[i], cnt_a[i], dout_a[i]);
      end
    end
    #1;
    Reset = 1'b0;
    for (int i = 0; i < NI; i++) m_cnt[i] = 0;
  endtask

  task automatic test_cumulative();
    logic       pat   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] exp_s [6] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, pat[k], 1'b0);
      n_checks++;
      if (st_a[0] !== exp_s[k] || dout_a[0] !== (exp_s[k] == 3'b100)) begin
        n_fail++;
        $display("FAIL cumulative edge %0d: state=%b dout=%b, want state=%b", k, st_a[0], dout_a[0], exp_s[k]);
      end
    end
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (dout_a[0] !== 1'b1 || cnt_a[0] !== 4'd2) begin
      n_fail++;
      $display("FAIL sticky_hold: dout=%b count=%0d, want dout=1 count=2", dout_a[0], cnt_a[0]);
    end
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (st_a[0] !== 3'b001 || cnt_a[0] !== 4'd0 || dout_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_done: state=%b count=%0d dout=%b, want 001/0/0", st_a[0], cnt_a[0], dout_a[0]);
    end
  endtask

  task automatic test_consecutive();
    logic       pat   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_c [6] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd3};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, pat[k], 1'b0);
      n_checks++;
      if (cnt_a[1] !== exp_c[k] || dout_a[1] !== (k == 5)) begin
        n_fail++;
        $display("FAIL consecutive edge %0d: count=%0d dout=%b, want count=%0d dout=%b",
                 k, cnt_a[1], dout_a[1], exp_c[k], (k == 5));
      end
    end
  endtask

  task automatic test_pulse();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (cnt_a[2] !== 4'((k % 2) + 1) || dout_a[2] !== (k % 2 == 1)) begin
        n_fail++;
        $display("FAIL pulse edge %0d: count=%0d dout=%b, want count=%0d dout=%b",
                 k, cnt_a[2], dout_a[2], (k % 2) + 1, (k % 2 == 1));
      end
    end
  endtask

  task automatic test_enable();
    logic       ens   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_c [7] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      step(ens[k], 1'b1, 1'b0);
      n_checks++;
      if (cnt_a[1] !== exp_c[k] || dout_a[1] !== (k == 6)) begin
        n_fail++;
        $display("FAIL enable edge %0d: count=%0d dout=%b, want count=%0d dout=%b",
                 k, cnt_a[1], dout_a[1], exp_c[k], (k == 6));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (st_a[1] !== 3'b010 || cnt_a[1] !== 4'd2) begin
      n_fail++;
      $display("FAIL pre_reset_midway: state=%b count=%0d, want 010/2", st_a[1], cnt_a[1]);
    end
    @(negedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    n_checks++;
    if (st_a[1] !== 3'b001 || cnt_a[1] !== 4'd0 || st_a[0] !== 3'b001) begin
      n_fail++;
      $display("FAIL async_reset: state=%b count=%0d, want 001/0", st_a[1], cnt_a[1]);
    end
    Reset = 1'b0;
    for (int i = 0; i < NI; i++) m_cnt[i] = 0;
    step(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (st_a[0] !== 3'b001 || cnt_a[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL clear_vs_hit: state=%b count=%0d, want 001/0", st_a[0], cnt_a[0]);
    end
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (st_a[0] !== 3'b010 || cnt_a[0] !== 4'd1) begin
      n_fail++;
      $display("FAIL fresh_run: state=%b count=%0d, want 010/1", st_a[0], cnt_a[0]);
    end
  endtask

  task automatic test_saturate();
    int bad;
    do_reset();
    bad = 0;
    for (int k = 0; k < 21; k++) begin
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (cnt_a[3] !== 4'd1 || st_a[3] !== 3'b100) begin
        n_fail++;
        bad++;
        if (bad < 4)
          $display("FAIL saturate edge %0d: count=%0d state=%b, want 1/100", k, cnt_a[3], st_a[3]);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    @(negedge Clock);
    Enable = 1'b0; Din = 1'b0; Clear = 1'b0;
    force g_dut[3].u_dut.state_q = 3'b011;
    #1;
    n_checks++;
    if (dout_a[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_dout: dout=%b, want 0", dout_a[3]);
    end
    release g_dut[3].u_dut.state_q;
    @(posedge Clock);
    #1;
    n_checks++;
    if (st_a[3] !== 3'b001 || cnt_a[3] !== 4'd0) begin
      n_fail++;
      $display("FAIL illegal_recover: state=%b count=%0d, want 001/0", st_a[3], cnt_a[3]);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic en, din, clr;
    int   bad;
    bad = 0;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      en  = ($urandom_range(0, 9) != 0);
      din = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 39) == 0);
      step(en, din, clr);
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (st_a[i] !== model_state(m_cnt[i], i) || cnt_a[i] !== 4'(m_cnt[i]) ||
            dout_a[i] !== (m_cnt[i] == P_COUNT[i])) begin
          n_fail++;
          bad++;
          if (bad < 10)
            $display("FAIL random[%0d] inst %0d: state=%b count=%0d dout=%b, want state=%b count=%0d",
                     k, i, st_a[i], cnt_a[i], dout_a[i], model_state(m_cnt[i], i), m_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset  = 1'b0;
    Enable = 1'b0;
    Din    = 1'b0;
    Clear  = 1'b0;
    for (int i = 0; i < NI; i++) m_cnt[i] = 0;
    test_reset();
    test_cumulative();
    test_consecutive();
    test_pulse();
    test_enable();
    test_async_reset();
    test_saturate();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
